// File: rtl/nx_node_pkg.sv
// Shared types and constants for the nx_node control path: command ids,
// payload field positions and the transmit-scheduler state encoding.
`timescale 1ns/1ps
package nx_node_pkg;

    localparam int DEF_PAYLOAD_W = 24;
    localparam int DEF_INSTR_W   = 15;
    localparam int DEF_IO_W      = 4;
    localparam int DEF_SLOTS     = 32;

    // SIGNAL_STATE carries the value at a fixed bit, the index sits at the bottom
    localparam int VALUE_BIT      = 8;
    localparam int SIG_INDEX_LSB  = 0;
    localparam int LOAD_SLOT_LSB  = 0;

    typedef enum logic [1:0] {
        CMD_LOAD_INSTR   = 2'd0,
        CMD_SIGNAL_STATE = 2'd1,
        CMD_RSVD_2       = 2'd2,
        CMD_RSVD_3       = 2'd3
    } cmd_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

endpackage

// File: rtl/nx_node_control_rr_arbiter.sv
// Round-robin picker: returns the first asserted request at or after ptr_i,
// wrapping around, plus a flag telling whether any request is present.
`timescale 1ns/1ps
module nx_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [PW-1:0] grant_o,
    output logic          any_o
);

    // Scan from the farthest offset down so the nearest request wins last
    always_comb begin
        int          sum_v;
        logic [PW-1:0] idx_v;
        grant_o = '0;
        any_o   = 1'b0;
        sum_v   = 0;
        idx_v   = '0;
        for (int off = N - 1; off >= 0; off--) begin
            sum_v   = int'(ptr_i) + off;
            sum_v   = (sum_v >= N) ? (sum_v - N) : sum_v;
            idx_v   = PW'(sum_v);
            grant_o = req_i[idx_v] ? idx_v : grant_o;
            any_o   = any_o | req_i[idx_v];
        end
    end

endmodule

// File: rtl/nx_node_control.sv
// Command decoder and output scheduler between receiver, core and transmitter:
// turns received commands into core load strobes and reports changed core outputs.
`timescale 1ns/1ps
module nx_node_control
    import nx_node_pkg::*;
#(
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int INSTR_W   = DEF_INSTR_W,
    parameter int IO_W      = DEF_IO_W,
    parameter int SLOTS     = DEF_SLOTS,
    parameter int SLOT_W    = $clog2(SLOTS),
    parameter int IDX_W     = $clog2(IO_W)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_setup,
    input  logic [1:0]           rx_command,
    input  logic [PAYLOAD_W-1:0] rx_payload,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [INSTR_W-1:0]   load_instr,
    output logic [SLOT_W-1:0]    load_slot,
    output logic                 load_valid,
    output logic                 in_value,
    output logic [IDX_W-1:0]     in_index,
    output logic                 in_valid,
    input  logic [IO_W-1:0]      out_values,
    input  logic [IO_W-1:0]      out_valids,
    output logic [1:0]           tx_command,
    output logic [PAYLOAD_W-1:0] tx_payload,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic [7:0]           drop_count
);

    cmd_t                 rx_cmd_s;
    logic                 rx_hs_s;

    logic                 rx_ready_q;
    logic                 load_valid_q, load_valid_d;
    logic [INSTR_W-1:0]   load_instr_q, load_instr_d;
    logic [SLOT_W-1:0]    load_slot_q,  load_slot_d;
    logic                 in_valid_q,   in_valid_d;
    logic                 in_value_q,   in_value_d;
    logic [IDX_W-1:0]     in_index_q,   in_index_d;
    logic [7:0]           drop_q,       drop_d;

    tx_state_t            tx_state_q,   tx_state_d;
    logic                 tx_valid_q,   tx_valid_d;
    logic [1:0]           tx_cmd_q,     tx_cmd_d;
    logic [PAYLOAD_W-1:0] tx_payload_q, tx_payload_d;
    logic [IDX_W-1:0]     sel_idx_q,    sel_idx_d;
    logic                 sel_val_q,    sel_val_d;
    logic [IO_W-1:0]      sent_q,       sent_d;
    logic [IO_W-1:0]      known_q,      known_d;
    logic [IDX_W-1:0]     rr_ptr_q,     rr_ptr_d;

    logic [IO_W-1:0]      pend_s;
    logic [IDX_W-1:0]     grant_s;
    logic                 any_s;

    assign rx_cmd_s = cmd_t'(rx_command);
    assign rx_hs_s  = rx_valid & rx_ready_q;

    generate
        if (SLOT_W + INSTR_W < PAYLOAD_W) begin : g_pad
            logic unused_s;
            assign unused_s = ^rx_payload[PAYLOAD_W-1:SLOT_W+INSTR_W];
        end
    endgenerate

    // Command decode; field registers only move when their strobe fires
    always_comb begin
        load_valid_d = 1'b0;
        load_instr_d = load_instr_q;
        load_slot_d  = load_slot_q;
        in_valid_d   = 1'b0;
        in_value_d   = in_value_q;
        in_index_d   = in_index_q;
        drop_d       = drop_q;
        if (rx_hs_s) begin
            case (rx_cmd_s)
                CMD_LOAD_INSTR: begin
                    if (in_setup) begin
                        load_valid_d = 1'b1;
                        load_instr_d = rx_payload[SLOT_W +: INSTR_W];
                        load_slot_d  = rx_payload[LOAD_SLOT_LSB +: SLOT_W];
                    end else begin
                        drop_d = sat_inc8(drop_q);
                    end
                end
                CMD_SIGNAL_STATE: begin
                    in_valid_d = 1'b1;
                    in_value_d = rx_payload[VALUE_BIT];
                    in_index_d = rx_payload[SIG_INDEX_LSB +: IDX_W];
                end
                default: begin
                    drop_d = sat_inc8(drop_q);
                end
            endcase
        end else begin
            drop_d = drop_q;
        end
    end

    // An output needs reporting when valid and never sent or differing from what was sent
    assign pend_s = out_valids & (~known_q | (out_values ^ sent_q));

    nx_rr_arbiter #(
        .N  (IO_W),
        .PW (IDX_W)
    ) u_arb (
        .req_i   (pend_s),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_s),
        .any_o   (any_s)
    );

    // Transmit scheduler: capture one changed output, hold it until accepted
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_valid_d   = tx_valid_q;
        tx_cmd_d     = tx_cmd_q;
        tx_payload_d = tx_payload_q;
        sel_idx_d    = sel_idx_q;
        sel_val_d    = sel_val_q;
        sent_d       = sent_q;
        known_d      = known_q;
        rr_ptr_d     = rr_ptr_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (any_s) begin
                    tx_valid_d                   = 1'b1;
                    tx_cmd_d                     = CMD_SIGNAL_STATE;
                    tx_payload_d                 = '0;
                    tx_payload_d[VALUE_BIT]      = out_values[grant_s];
                    tx_payload_d[SIG_INDEX_LSB +: IDX_W] = grant_s;
                    sel_idx_d                    = grant_s;
                    sel_val_d                    = out_values[grant_s];
                    tx_state_d                   = TX_SEND;
                end else begin
                    tx_valid_d = 1'b0;
                end
            end
            TX_SEND: begin
                if (tx_ready) begin
                    tx_valid_d         = 1'b0;
                    sent_d[sel_idx_q]  = sel_val_q;
                    known_d[sel_idx_q] = 1'b1;
                    rr_ptr_d           = (sel_idx_q == IDX_W'(IO_W - 1)) ? '0
                                                                         : (sel_idx_q + 1'b1);
                    tx_state_d         = TX_IDLE;
                end else begin
                    tx_valid_d = 1'b1;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_ready_q   <= 1'b0;
            load_valid_q <= 1'b0;
            load_instr_q <= '0;
            load_slot_q  <= '0;
            in_valid_q   <= 1'b0;
            in_value_q   <= 1'b0;
            in_index_q   <= '0;
            drop_q       <= 8'd0;
            tx_state_q   <= TX_IDLE;
            tx_valid_q   <= 1'b0;
            tx_cmd_q     <= 2'd0;
            tx_payload_q <= '0;
            sel_idx_q    <= '0;
            sel_val_q    <= 1'b0;
            sent_q       <= '0;
            known_q      <= '0;
            rr_ptr_q     <= '0;
        end else begin
            rx_ready_q   <= 1'b1;
            load_valid_q <= load_valid_d;
            load_instr_q <= load_instr_d;
            load_slot_q  <= load_slot_d;
            in_valid_q   <= in_valid_d;
            in_value_q   <= in_value_d;
            in_index_q   <= in_index_d;
            drop_q       <= drop_d;
            tx_state_q   <= tx_state_d;
            tx_valid_q   <= tx_valid_d;
            tx_cmd_q     <= tx_cmd_d;
            tx_payload_q <= tx_payload_d;
            sel_idx_q    <= sel_idx_d;
            sel_val_q    <= sel_val_d;
            sent_q       <= sent_d;
            known_q      <= known_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

    assign rx_ready   = rx_ready_q;
    assign load_valid = load_valid_q;
    assign load_instr = load_instr_q;
    assign load_slot  = load_slot_q;
    assign in_valid   = in_valid_q;
    assign in_value   = in_value_q;
    assign in_index   = in_index_q;
    assign drop_count = drop_q;
    assign tx_valid   = tx_valid_q;
    assign tx_command = tx_cmd_q;
    assign tx_payload = tx_payload_q;

endmodule
